// File: rtl/yin_tau_search_if.sv
// Diff-memory read port and control/result signals of the YIN tau search.
// master: the search engine; slave: the environment (memory arbiter, sequencer).
interface yin_tau_search_if #(
  parameter int unsigned DIFF_WIDTH = 32,
  parameter int unsigned TAUMAX     = 2048
);
  localparam int unsigned AW = $clog2(TAUMAX);

  logic                  start_in;
  logic                  busy_out;
  logic                  rd_req_out;
  logic                  rd_grant_in;
  logic                  rd_en_out;
  logic [AW-1:0]         rd_addr_out;
  logic [DIFF_WIDTH-1:0] rd_data_in;
  logic                  tau_valid_out;
  logic                  found_out;
  logic [AW-1:0]         tau_out;

  modport master (
    input  start_in, rd_grant_in, rd_data_in,
    output busy_out, rd_req_out, rd_en_out, rd_addr_out,
           tau_valid_out, found_out, tau_out
  );

  modport slave (
    output start_in, rd_grant_in, rd_data_in,
    input  busy_out, rd_req_out, rd_en_out, rd_addr_out,
           tau_valid_out, found_out, tau_out
  );
endinterface

// File: rtl/yin_tau_search.sv
// YIN post-window pitch search: scans d(tau) in ascending tau, applies the
// division-free cumulative-mean-normalized threshold test and reports the
// first local minimum below threshold (tau >= TAU_MIN) as the pitch period.
module yin_tau_search #(
  parameter int unsigned DIFF_WIDTH   = 32,
  parameter int unsigned TAUMAX       = 2048,
  parameter int unsigned TAU_MIN      = 40,
  parameter int unsigned THRESH_NUM   = 26,
  parameter int unsigned THRESH_SHIFT = 8,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  yin_tau_search_if.master bus
);
  localparam int unsigned AW = $clog2(TAUMAX);
  localparam int unsigned SW = DIFF_WIDTH + AW;
  localparam int unsigned CW = SW + THRESH_SHIFT + 1;
  localparam int unsigned OW = $clog2(RD_LATENCY + 1) + 1;
  localparam logic [AW-1:0] LAST_TAU = AW'(TAUMAX - 1);
  localparam logic [AW-1:0] MIN_TAU  = AW'(TAU_MIN);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DESCEND, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;

  logic                  start_acc;
  logic                  issuing;
  logic                  rd_en;
  logic                  busy;
  logic                  tau_valid;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         issue_addr;
  logic                  all_issued;
  logic [RD_LATENCY-1:0] vpipe;
  logic                  ret_valid;
  logic [OW-1:0]         outstanding;
  logic [AW-1:0]         ret_tau;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         sum_nx;
  logic [CW-1:0]         lhs;
  logic [CW-1:0]         rhs;
  logic                  p_valid;
  logic [AW-1:0]         p_tau;
  logic [DIFF_WIDTH-1:0] p_d;
  logic                  p_below;
  logic                  crossing;
  logic                  p_last;
  logic [DIFF_WIDTH-1:0] best_d;
  logic                  res_found;
  logic [AW-1:0]         res_tau;
  logic                  found_q;
  logic [AW-1:0]         tau_q;

  assign start_acc = (state == S_IDLE) && bus.start_in;
  assign ret_valid = vpipe[RD_LATENCY-1];
  assign crossing  = p_valid && p_below && (p_tau >= MIN_TAU);
  assign p_last    = (p_tau == LAST_TAU);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: decisions are taken on the registered compare stage
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.start_in) state_nx = S_SCAN;
      S_SCAN: begin
        if (crossing) state_nx = p_last ? S_DRAIN : S_DESCEND;
        else if (p_valid && p_last) state_nx = S_DRAIN;
      end
      S_DESCEND: if (p_valid && ((p_d >= best_d) || p_last)) state_nx = S_DRAIN;
      S_DRAIN:   if (outstanding == '0) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Output logic: read issue is gated by grant, result pulse in DONE
  always_comb begin
    busy      = (state == S_SCAN) || (state == S_DESCEND) || (state == S_DRAIN);
    issuing   = ((state == S_SCAN) || (state == S_DESCEND)) && !all_issued;
    rd_en     = issuing && bus.rd_grant_in;
    rd_addr   = issuing ? issue_addr : '0;
    tau_valid = (state == S_DONE);
  end

  assign bus.busy_out      = busy;
  assign bus.rd_req_out    = issuing;
  assign bus.rd_en_out     = rd_en;
  assign bus.rd_addr_out   = rd_addr;
  assign bus.tau_valid_out = tau_valid;
  assign bus.found_out     = found_q;
  assign bus.tau_out       = tau_q;

  // Read address generator, advancing only on granted cycles
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      issue_addr <= '0;
      all_issued <= 1'b0;
    end else if (start_acc) begin
      issue_addr <= AW'(1);
      all_issued <= 1'b0;
    end else if (rd_en) begin
      if (issue_addr == LAST_TAU) all_issued <= 1'b1;
      else                        issue_addr <= issue_addr + 1'b1;
    end
  end

  // Read-latency valid pipeline and outstanding-read counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vpipe       <= '0;
      outstanding <= '0;
    end else begin
      vpipe[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
      outstanding <= outstanding + OW'(rd_en) - OW'(ret_valid);
    end
  end

  // Running sum and full-width threshold products for the returning word
  always_comb begin
    sum_nx = sum + SW'(bus.rd_data_in);
    lhs    = (CW'(bus.rd_data_in) * CW'(ret_tau)) << THRESH_SHIFT;
    rhs    = CW'(THRESH_NUM) * CW'(sum_nx);
  end

  // Compare stage: register tau, d and the below-threshold flag per returned word.
  // Reads return in issue order, so the returning tau is a simple counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum     <= '0;
      ret_tau <= '0;
      p_valid <= 1'b0;
      p_tau   <= '0;
      p_d     <= '0;
      p_below <= 1'b0;
    end else if (start_acc) begin
      sum     <= '0;
      ret_tau <= AW'(1);
      p_valid <= 1'b0;
    end else begin
      p_valid <= ret_valid;
      if (ret_valid) begin
        sum     <= sum_nx;
        ret_tau <= ret_tau + 1'b1;
        p_tau   <= ret_tau;
        p_d     <= bus.rd_data_in;
        p_below <= (lhs < rhs);
      end
    end
  end

  // Best-minimum tracking and held result outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      best_d    <= '0;
      res_found <= 1'b0;
      res_tau   <= '0;
      found_q   <= 1'b0;
      tau_q     <= '0;
    end else begin
      if (start_acc) begin
        res_found <= 1'b0;
        res_tau   <= '0;
      end
      if ((state == S_SCAN) && crossing) begin
        best_d    <= p_d;
        res_found <= 1'b1;
        res_tau   <= p_tau;
      end
      if ((state == S_DESCEND) && p_valid && (p_d < best_d)) begin
        best_d  <= p_d;
        res_tau <= p_tau;
      end
      if ((state == S_DRAIN) && (outstanding == '0)) begin
        found_q <= res_found;
        tau_q   <= res_tau;
      end
    end
  end
endmodule

// File: tb/tb_yin_tau_search.sv
// Self-checking bench for yin_tau_search: directed/random d(tau) tables
// against a plain-arithmetic YIN reference, plus control corner cases.
module tb_yin_tau_search;
  localparam int TAUMAX = 2048;

  typedef struct {
    int pattern;    // 0 dip, 1 flat, 2 TAU_MIN guard, 3 descent to end, 4 random
    bit throttle;
    bit use_model;
    bit exp_found;
    int exp_tau;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yin_tau_search_if #(.DIFF_WIDTH(32), .TAUMAX(TAUMAX)) bus ();

  yin_tau_search #(
    .DIFF_WIDTH(32), .TAUMAX(TAUMAX), .TAU_MIN(40),
    .THRESH_NUM(26), .THRESH_SHIFT(8), .RD_LATENCY(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  logic [31:0] d_mem [0:TAUMAX-1];
  logic [31:0] r1, r2;
  int tests_run = 0;
  int tests_failed = 0;
  int addr_q[$];
  int viol;
  int pulses;
  bit cap_found;
  int cap_tau;

  // Diff memory with two-cycle read latency; poison data when not read
  always @(posedge clk) begin
    r1 <= bus.rd_en_out ? d_mem[bus.rd_addr_out] : 32'hDEADBEEF;
    r2 <= r1;
  end
  assign bus.rd_data_in = r2;

  // Monitor: read addresses, grant violations and result pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_en_out) begin
        addr_q.push_back(int'(bus.rd_addr_out));
        if (!bus.rd_grant_in) viol++;
      end
      if (bus.tau_valid_out) begin
        pulses++;
        cap_found = bus.found_out;
        cap_tau   = int'(bus.tau_out);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < TAUMAX; i++) d_mem[i] = 32'd1000;
    case (pat)
      0: begin
        d_mem[98] = 400; d_mem[99] = 100; d_mem[100] = 20;
        d_mem[101] = 60; d_mem[102] = 900;
      end
      2: d_mem[20] = 0;
      3: for (int i = 1990; i < TAUMAX; i++) d_mem[i] = 32'(100 - (i - 1990));
      4: begin
        int p;
        for (int i = 0; i < TAUMAX; i++) d_mem[i] = $urandom_range(800, 1200);
        p = $urandom_range(30, 1900);
        for (int i = 0; i < 5; i++) d_mem[p+i] = $urandom_range(0, 150);
      end
      default: ;
    endcase
  endtask

  // Reference: sequential YIN rule on the memory contents in plain 64-bit arithmetic
  function automatic void model(output bit f, output int t);
    logic [63:0] s, d, bd;
    bit desc;
    int bt;
    s = 0; desc = 0; bd = 0; bt = 0;
    for (int tau = 1; tau < TAUMAX; tau++) begin
      d = 64'(d_mem[tau]);
      s = s + d;
      if (!desc) begin
        if (((d * 64'(tau)) << 8) < 64'd26 * s && tau >= 40) begin
          desc = 1; bd = d; bt = tau;
        end
      end else if (d < bd) begin
        bd = d; bt = tau;
      end else break;
    end
    f = desc;
    t = desc ? bt : 0;
  endfunction

  task automatic run_window(input bit thr, input int restart_at, output bit to);
    addr_q.delete();
    viol = 0;
    pulses = 0;
    bus.rd_grant_in = 1'b1;
    @(posedge clk); #1 bus.start_in = 1'b1;
    @(posedge clk); #1 bus.start_in = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      bus.start_in    = (n == restart_at);
      bus.rd_grant_in = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (pulses > 0) begin
        to = 1'b0;
        break;
      end
    end
    bus.start_in = 1'b0;
    bus.rd_grant_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_window(input string tag, input bit to, input bit ef, input int et,
                              input bit full_scan);
    int bad;
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i + 1) bad++;
    check({tag, " timeout"}, to, 0);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " found"}, cap_found, ef);
    check({tag, " tau"}, cap_tau, et);
    check({tag, " grant_viol"}, viol, 0);
    check({tag, " addr_seq"}, bad, 0);
    if (full_scan) check({tag, " read_count"}, addr_q.size(), TAUMAX - 1);
  endtask

  initial begin
    vec_t vecs[$];
    bit to, ef;
    int et;

    vecs.push_back('{0, 1'b0, 1'b0, 1'b1, 100});
    vecs.push_back('{1, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 1'b0, 1'b1, 100});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b1, 2047});
    vecs.push_back('{4, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{4, 1'b1, 1'b1, 1'b0, 0});
    vecs.push_back('{4, 1'b1, 1'b1, 1'b0, 0});

    bus.start_in = 1'b0;
    bus.rd_grant_in = 1'b0;
    fill(1);
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", bus.busy_out, 0);
    check("rst rd_req", bus.rd_req_out, 0);
    check("rst rd_en", bus.rd_en_out, 0);
    check("rst rd_addr", bus.rd_addr_out, 0);
    check("rst tau_valid", bus.tau_valid_out, 0);
    check("rst found", bus.found_out, 0);
    check("rst tau", bus.tau_out, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      fill(vecs[k].pattern);
      if (vecs[k].use_model) model(ef, et);
      else begin
        ef = vecs[k].exp_found;
        et = vecs[k].exp_tau;
      end
      run_window(vecs[k].throttle, -1, to);
      check_window($sformatf("vec%0d", k), to, ef, et, !ef);
    end

    // start pulsed while busy must be ignored
    fill(0);
    run_window(1'b0, 40, to);
    check_window("restart_busy", to, 1'b1, 100, 1'b0);

    // async reset mid-SCAN clears outputs immediately and cancels the result
    pulses = 0;
    @(posedge clk); #1 bus.start_in = 1'b1;
    @(posedge clk); #1 bus.start_in = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("midscan busy", bus.busy_out, 1);
    check("midscan rd_req", bus.rd_req_out, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async busy", bus.busy_out, 0);
    check("rst_async rd_req", bus.rd_req_out, 0);
    check("rst_async rd_en", bus.rd_en_out, 0);
    check("rst_async found", bus.found_out, 0);
    check("rst_async tau", bus.tau_out, 0);
    check("rst_async tau_valid", bus.tau_valid_out, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst no_pulse", pulses, 0);
    check("post_rst idle", bus.busy_out, 0);

    // fresh start after reset
    run_window(1'b1, -1, to);
    check_window("after_rst", to, 1'b1, 100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
